// File: rtl/rgb_gray_stream_pkg.sv
// rgb_gray_stream shared constants: luma coefficients, rounding, frame size.
// FSM state encoding; also reused by the Sobel data buffer.
package rgb_gray_stream_pkg;

  localparam int ROWS_DEF = 480;
  localparam int COLS_DEF = 360;

  localparam logic [15:0] C_R   = 16'd77;
  localparam logic [15:0] C_G   = 16'd150;
  localparam logic [15:0] C_B   = 16'd29;
  localparam logic [15:0] C_RND = 16'd128;
  localparam int          C_SHIFT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/rgb_gray_stream_if.sv
// Pixel-in / gray-out stream bundle.
// master: pixel source + kernel sink; slave: rgb_gray_stream.
interface rgb_gray_stream_if;

  logic [23:0] rgb_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  data_o;
  logic        we_o;

  modport master (
    output rgb_i, valid_i,
    input  ready_o, data_o, we_o
  );

  modport slave (
    input  rgb_i, valid_i,
    output ready_o, data_o, we_o
  );

endinterface

// File: rtl/rgb_gray_stream_rgb2gray_pipe.sv
// 3-stage RGB->luma datapath: products, rounded sum, shift.
// Ports: clk, rst_n, in_valid, rgb -> out_valid, gray (held when idle).
module rgb2gray_pipe
  import rgb_gray_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [23:0] rgb,
  output logic        out_valid,
  output logic [7:0]  gray
);

  logic [15:0] p_r, p_g, p_b;
  logic [15:0] sum;
  logic        v1, v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r       <= '0;
      p_g       <= '0;
      p_b       <= '0;
      sum       <= '0;
      gray      <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      p_r       <= C_R * {8'd0, rgb[23:16]};
      p_g       <= C_G * {8'd0, rgb[15:8]};
      p_b       <= C_B * {8'd0, rgb[7:0]};
      // peak is 65408, fits 16 bits
      sum       <= p_r + p_g + p_b + C_RND;
      if (v2)
        gray    <= sum[C_SHIFT +: 8];
    end
  end

endmodule

// File: rtl/rgb_gray_stream.sv
// Frame feeder for the Sobel kernel: FSM, pixel counter, flags.
// Ports: clk, rst (async low), start_i, bus (slave), busy_o, done_o, overrun_o.
module rgb_gray_stream
  import rgb_gray_stream_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  parameter int CNT_W = 18
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  rgb_gray_stream_if.slave bus,
  output logic           busy_o,
  output logic           done_o,
  output logic           overrun_o
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(ROWS * COLS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       dcnt;
  logic             rdy;
  logic             acc;

  assign acc         = bus.valid_i & rdy;
  assign bus.ready_o = rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      rdy       <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (bus.valid_i && !rdy)
        overrun_o <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state  <= STREAM;
            cnt    <= '0;
            rdy    <= 1'b1;
            busy_o <= 1'b1;
          end
        end
        STREAM: begin
          if (acc) begin
            if (cnt == LAST) begin
              state <= DRAIN;
              rdy   <= 1'b0;
              dcnt  <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          // done lines up with the last sample's we_o
          dcnt <= dcnt + 1'b1;
          if (dcnt == 2'd1)
            done_o <= 1'b1;
          if (dcnt == 2'd2) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          rdy    <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  rgb2gray_pipe u_pipe (
    .clk       (clk),
    .rst_n     (rst),
    .in_valid  (acc),
    .rgb       (bus.rgb_i),
    .out_valid (bus.we_o),
    .gray      (bus.data_o)
  );

endmodule

// File: tb/tb_rgb_gray_stream.sv
// Self-checking bench for rgb_gray_stream (4x3 frames).
// Cycle-indexed reference: accept at cycle c -> sample at c+3.
module tb_rgb_gray_stream;

  localparam int N = 12;

  logic clk;
  logic rst_n;
  logic start;
  logic busy, done, ovr;

  rgb_gray_stream_if bus ();

  rgb_gray_stream #(
    .ROWS  (4),
    .COLS  (3),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .start_i   (start),
    .bus       (bus.slave),
    .busy_o    (busy),
    .done_o    (done),
    .overrun_o (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int          cyc;
  bit          streaming;
  int          drain_end;
  int          acc;
  bit          ovr_m;
  logic [7:0]  last_data;
  logic [7:0]  gmap [int];
  int          we_seen;
  logic [23:0] pal [N];

  function automatic logic [7:0] gray_of(input logic [23:0] p);
    int r, g, b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    return 8'((77 * r + 150 * g + 29 * b + 128) / 256);
  endfunction

  task automatic chk1(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%0b exp=%0b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit st, input bit v, input logic [23:0] px);
    bit rdy, bsy, wexp;
    start       = st;
    bus.valid_i = v;
    bus.rgb_i   = px;
    rdy  = streaming;
    bsy  = streaming || (cyc <= drain_end);
    wexp = gmap.exists(cyc);
    if (wexp) last_data = gmap[cyc];
    @(negedge clk);
    chk1("ready", bus.ready_o, rdy);
    chk1("busy", busy, bsy);
    chk1("we", bus.we_o, wexp);
    chk8("data", bus.data_o, last_data);
    chk1("done", done, cyc == drain_end);
    chk1("overrun", ovr, ovr_m);
    if (bus.we_o) we_seen++;
    if (v && !rdy) ovr_m = 1'b1;
    if (v && rdy) begin
      gmap[cyc + 3] = gray_of(px);
      acc++;
      if (acc == N) begin
        streaming = 1'b0;
        drain_end = cyc + 3;
      end
    end
    if (st && !bsy) begin
      streaming = 1'b1;
      acc       = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_clear();
    gmap.delete();
    streaming = 1'b0;
    drain_end = -100;
    acc       = 0;
    ovr_m     = 1'b0;
    last_data = 8'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk1("rst_we", bus.we_o, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", bus.ready_o, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk8("rst_data", bus.data_o, 8'd0);
    chk1("rst_ovr", ovr, 1'b0);
    model_clear();
    start       = 1'b0;
    bus.valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    bus.valid_i = 1'b0;
    bus.rgb_i   = '0;
    cyc         = 0;
    we_seen     = 0;
    model_clear();
    pal[0] = 24'hFFFFFF;
    pal[1] = 24'h000000;
    pal[2] = 24'hFF0000;
    pal[3] = 24'h00FF00;
    pal[4] = 24'h0000FF;
    for (int i = 5; i < N; i++) pal[i] = 24'($urandom);

    // reset state
    @(negedge clk);
    chk1("init_ready", bus.ready_o, 1'b0);
    chk1("init_busy", busy, 1'b0);
    chk1("init_we", bus.we_o, 1'b0);
    chk8("init_data", bus.data_o, 8'd0);
    chk1("init_done", done, 1'b0);
    chk1("init_ovr", ovr, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;

    // colour mapping, back-to-back
    we_seen = 0;
    step(1'b1, 1'b0, 24'h0);
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, pal[i]);
    repeat (5) step(1'b0, 1'b0, 24'h0);
    chk8("f1_we_count", 8'(we_seen), 8'(N));

    // overrun in IDLE, gapped frame, overrun in DRAIN
    we_seen = 0;
    step(1'b0, 1'b1, 24'h123456);
    step(1'b1, 1'b0, 24'h0);
    for (int i = 0; i < 2 * N; i++)
      step(1'b0, (i % 2) == 0, 24'($urandom));
    step(1'b0, 1'b1, 24'hABCDEF);
    repeat (4) step(1'b0, 1'b0, 24'h0);
    chk8("f2_we_count", 8'(we_seen), 8'(N));

    // start ignored mid-stream and in the done cycle
    we_seen = 0;
    step(1'b1, 1'b0, 24'h0);
    for (int i = 0; i < N; i++)
      step(i == 5, 1'b1, 24'($urandom));
    step(1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 24'h0);
    chk8("f3_we_count", 8'(we_seen), 8'(N));

    // start right after done, random valid pattern
    we_seen = 0;
    step(1'b1, 1'b0, 24'h0);
    for (int i = 0; i < 200 && (streaming || acc < N); i++)
      step(1'b0, 1'($urandom), 24'($urandom));
    chk8("f4_accepts", 8'(acc), 8'(N));
    repeat (5) step(1'b0, 1'b0, 24'h0);
    chk8("f4_we_count", 8'(we_seen), 8'(N));

    // reset mid-frame, then a clean frame
    step(1'b1, 1'b0, 24'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 24'($urandom));
    do_reset();
    repeat (4) step(1'b0, 1'b0, 24'h0);
    we_seen = 0;
    step(1'b1, 1'b0, 24'h0);
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, 24'($urandom));
    repeat (5) step(1'b0, 1'b0, 24'h0);
    chk8("f5_we_count", 8'(we_seen), 8'(N));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
